// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM slave.
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Owner of the single SRAM port in a given cycle
  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

  // Ceiling log2 for elaboration-time width calculations
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = 32'(i + 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4-Lite bus bundle between an interconnect master and the SRAM slave.
interface axi_sram_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] axi_awaddr;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [DATA_W-1:0] axi_wdata;
  logic [STRB_W-1:0] axi_wstrb;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [ADDR_W-1:0] axi_araddr;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rvalid;
  logic              axi_rready;

  modport slave (
    input  axi_awaddr, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready
  );

  modport master (
    output axi_awaddr, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready
  );

endinterface

// File: rtl/sram_sp_be.sv
// Single-port byte-enabled synchronous RAM with a one-cycle registered read.
module sram_sp_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned IDX_W  = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // Byte-lane writes; array contents are never reset
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read register only moves on a read, so it holds while a response waits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en && !i_we) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-Lite slave in front of a single-port byte-enabled SRAM.
// Independent AW/W capture, SLVERR on out-of-range, round-robin port sharing.
// Define AXI_SRAM_RD_PIPE_EN to add an output register (read latency 2).
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic             aclk,
  input  logic             areset,
  axi_sram_slave_if.slave  s_axi
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = clog2(STRB_W);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic              r_awready, r_wready, r_arready;
  logic              r_bvalid, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic              r_aw_full, r_w_full, r_rd_busy, r_rd_issued;
  gnt_e              r_ptr;
  logic [ADDR_W-1:0] r_awaddr, r_araddr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  logic              w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic              w_wr_req, w_rd_req, w_wr_fire, w_rd_issue;
  logic              w_aw_full_nxt, w_w_full_nxt, w_rd_busy_nxt;
  logic              w_rvalid_set;
  gnt_e              w_ptr_nxt;
  logic [ADDR_W-1:0] w_wr_off, w_wr_idx, w_rd_off, w_rd_idx;
  logic              w_wr_ok, w_rd_ok;
  logic              w_ram_en, w_ram_we;
  logic [IDX_W-1:0]  w_ram_addr;
  logic [DATA_W-1:0] w_ram_q;

  assign w_aw_hs = s_axi.axi_awvalid && r_awready;
  assign w_w_hs  = s_axi.axi_wvalid  && r_wready;
  assign w_ar_hs = s_axi.axi_arvalid && r_arready;
  assign w_b_hs  = r_bvalid && s_axi.axi_bready;
  assign w_r_hs  = r_rvalid && s_axi.axi_rready;

  // Word index and range check; byte-offset bits drop out in the shift
  assign w_wr_off = r_awaddr - BASE_ADDR;
  assign w_wr_idx = w_wr_off >> OFF_W;
  assign w_wr_ok  = (r_awaddr >= BASE_ADDR) && (w_wr_idx < ADDR_W'(DEPTH));
  assign w_rd_off = r_araddr - BASE_ADDR;
  assign w_rd_idx = w_rd_off >> OFF_W;
  assign w_rd_ok  = (r_araddr >= BASE_ADDR) && (w_rd_idx < ADDR_W'(DEPTH));

  assign w_wr_req = r_aw_full && r_w_full && !r_bvalid;
  assign w_rd_req = r_rd_busy && !r_rd_issued;

  // Round-robin grant of the SRAM port; pointer only moves on contention
  always_comb begin
    w_wr_fire  = 1'b0;
    w_rd_issue = 1'b0;
    w_ptr_nxt  = r_ptr;
    if (w_wr_req && w_rd_req) begin
      if (r_ptr == GNT_WR) w_wr_fire  = 1'b1;
      else                 w_rd_issue = 1'b1;
      w_ptr_nxt = (r_ptr == GNT_WR) ? GNT_RD : GNT_WR;
    end else begin
      w_wr_fire  = w_wr_req;
      w_rd_issue = w_rd_req;
    end
  end

  // Next occupancy of the holding registers, which also drives the readys
  always_comb begin
    w_aw_full_nxt = r_aw_full;
    w_w_full_nxt  = r_w_full;
    w_rd_busy_nxt = r_rd_busy;
    if (w_aw_hs)        w_aw_full_nxt = 1'b1;
    else if (w_wr_fire) w_aw_full_nxt = 1'b0;
    if (w_w_hs)         w_w_full_nxt  = 1'b1;
    else if (w_wr_fire) w_w_full_nxt  = 1'b0;
    if (w_ar_hs)        w_rd_busy_nxt = 1'b1;
    else if (w_r_hs)    w_rd_busy_nxt = 1'b0;
  end

  // Control state, readys and response channels
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_aw_full   <= 1'b0;
      r_w_full    <= 1'b0;
      r_rd_busy   <= 1'b0;
      r_rd_issued <= 1'b0;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_arready   <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rresp     <= RESP_OKAY;
      r_ptr       <= GNT_WR;
    end else begin
      r_aw_full <= w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      r_rd_busy <= w_rd_busy_nxt;
      r_awready <= !w_aw_full_nxt;
      r_wready  <= !w_w_full_nxt;
      r_arready <= !w_rd_busy_nxt;
      r_ptr     <= w_ptr_nxt;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end
      if (w_rd_issue) begin
        r_rd_issued <= 1'b1;
        r_rresp     <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (w_r_hs) begin
        r_rd_issued <= 1'b0;
      end
      if (w_rvalid_set)  r_rvalid <= 1'b1;
      else if (w_r_hs)   r_rvalid <= 1'b0;
    end
  end

  // Request payload capture; no reset needed on data
  always_ff @(posedge aclk) begin
    if (w_aw_hs) r_awaddr <= s_axi.axi_awaddr;
    if (w_w_hs) begin
      r_wdata <= s_axi.axi_wdata;
      r_wstrb <= s_axi.axi_wstrb;
    end
    if (w_ar_hs) r_araddr <= s_axi.axi_araddr;
  end

  // Out-of-range requests never touch the array
  assign w_ram_en   = (w_wr_fire && w_wr_ok) || (w_rd_issue && w_rd_ok);
  assign w_ram_we   = w_wr_fire;
  assign w_ram_addr = w_wr_fire ? IDX_W'(w_wr_idx) : IDX_W'(w_rd_idx);

  sram_sp_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_sram (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_be    (r_wstrb),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

`ifdef AXI_SRAM_RD_PIPE_EN
  logic              r_rd_p1;
  logic [DATA_W-1:0] r_rdata;

  // Extra output stage: data lands one cycle after the SRAM register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rd_p1 <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rd_p1 <= w_rd_issue;
      if (r_rd_p1) r_rdata <= (r_rresp == RESP_SLVERR) ? '0 : w_ram_q;
    end
  end

  assign w_rvalid_set    = r_rd_p1;
  assign s_axi.axi_rdata = r_rdata;
`else
  assign w_rvalid_set    = w_rd_issue;
  assign s_axi.axi_rdata = (r_rresp == RESP_SLVERR) ? '0 : w_ram_q;
`endif

  assign s_axi.axi_awready = r_awready;
  assign s_axi.axi_wready  = r_wready;
  assign s_axi.axi_arready = r_arready;
  assign s_axi.axi_bvalid  = r_bvalid;
  assign s_axi.axi_bresp   = r_bresp;
  assign s_axi.axi_rvalid  = r_rvalid;
  assign s_axi.axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (32-bit, 512 words, base 0).
module tb_axi_sram_slave;

  logic aclk = 1'b0;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  axi_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_sram_slave #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .DEPTH     (512),
    .BASE_ADDR (32'h0)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axi  (bus.slave)
  );

  always #5 aclk = ~aclk;

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Full write transaction with bready high; ok=0 on timeout
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic ok);
    logic aw_hs, w_hs;
    ok = 1'b0;
    resp = 2'bxx;
    bus.axi_awaddr = addr;
    bus.axi_wdata = data;
    bus.axi_wstrb = strb;
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid = 1'b1;
    bus.axi_bready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      aw_hs = bus.axi_awvalid && bus.axi_awready;
      w_hs = bus.axi_wvalid && bus.axi_wready;
      if (bus.axi_bvalid) begin
        resp = bus.axi_bresp;
        ok = 1'b1;
      end
      tick();
      if (aw_hs) bus.axi_awvalid = 1'b0;
      if (w_hs) bus.axi_wvalid = 1'b0;
    end
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
  endtask

  // Full read transaction with rready high; ok=0 on timeout
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output logic ok);
    logic ar_hs;
    ok = 1'b0;
    data = 'x;
    resp = 2'bxx;
    bus.axi_araddr = addr;
    bus.axi_arvalid = 1'b1;
    bus.axi_rready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ar_hs = bus.axi_arvalid && bus.axi_arready;
      if (bus.axi_rvalid) begin
        data = bus.axi_rdata;
        resp = bus.axi_rresp;
        ok = 1'b1;
      end
      tick();
      if (ar_hs) bus.axi_arvalid = 1'b0;
    end
    bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({bus.axi_awready, bus.axi_wready, bus.axi_arready, bus.axi_bvalid, bus.axi_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {bus.axi_awready, bus.axi_wready, bus.axi_arready, bus.axi_bvalid, bus.axi_rvalid});
    end
    checks++;
    if ({bus.axi_bresp, bus.axi_rresp, bus.axi_rdata} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h expected all 0", bus.axi_bresp, bus.axi_rresp, bus.axi_rdata);
    end
    areset = 1'b0;
    tick();
    checks++;
    if ({bus.axi_awready, bus.axi_wready, bus.axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 111", {bus.axi_awready, bus.axi_wready, bus.axi_arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp;
    logic [31:0] data;
    logic ok;
    do_write(32'h100, 32'hDEADBEEF, 4'hF, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00) begin
      errors++;
      $display("FAIL basic_bresp: ok=%0b bresp=%b expected 00", ok, resp);
    end
    do_read(32'h100, data, resp, ok);
    checks++;
    if (!ok || data !== 32'hDEADBEEF || resp !== 2'b00) begin
      errors++;
      $display("FAIL basic_read: ok=%0b rdata=%h rresp=%b expected DEADBEEF/00", ok, data, resp);
    end
    do_write(32'h100, 32'h00001234, 4'b0011, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00) begin
      errors++;
      $display("FAIL strb_bresp: ok=%0b bresp=%b expected 00", ok, resp);
    end
    do_read(32'h100, data, resp, ok);
    checks++;
    if (!ok || data !== 32'hDEAD1234) begin
      errors++;
      $display("FAIL strb_read: ok=%0b rdata=%h expected DEAD1234", ok, data);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    logic [31:0] data;
    logic ok;
    int nb;
    bus.axi_bready = 1'b0;
    bus.axi_wdata = 32'hA5A5A5A5;
    bus.axi_wstrb = 4'hF;
    bus.axi_wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      ok = bus.axi_wready;
      tick();
    end
    bus.axi_wvalid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wfirst_w_hs: wready never seen, expected 1");
    end
    tick(); tick();
    bus.axi_awaddr = 32'h104;
    bus.axi_awvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      ok = bus.axi_awready;
      tick();
    end
    bus.axi_awvalid = 1'b0;
    checks++;
    if (!ok || bus.axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL wfirst_b_early: aw_hs=%0b bvalid=%b expected 1/0", ok, bus.axi_bvalid);
    end
    tick();
    checks++;
    if (bus.axi_bvalid !== 1'b1 || bus.axi_bresp !== 2'b00) begin
      errors++;
      $display("FAIL wfirst_b_timing: bvalid=%b bresp=%b expected 1/00", bus.axi_bvalid, bus.axi_bresp);
    end
    bus.axi_bready = 1'b1;
    tick();
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.axi_bvalid) nb++;
      tick();
    end
    bus.axi_bready = 1'b0;
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL wfirst_single_b: extra bvalid cycles=%0d expected 0", nb);
    end
    do_read(32'h104, data, resp, ok);
    checks++;
    if (!ok || data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL wfirst_read: ok=%0b rdata=%h expected A5A5A5A5", ok, data);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp;
    logic [31:0] data;
    logic ok;
    do_write(32'h000, 32'h0BADF00D, 4'hF, resp, ok);
    do_write(32'h7FC, 32'h5A5A0FF0, 4'hF, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00) begin
      errors++;
      $display("FAIL oor_last_word_bresp: ok=%0b bresp=%b expected 00", ok, resp);
    end
    do_write(32'h800, 32'hFFFFFFFF, 4'hF, resp, ok);
    checks++;
    if (!ok || resp !== 2'b10) begin
      errors++;
      $display("FAIL oor_bresp: ok=%0b bresp=%b expected 10", ok, resp);
    end
    do_read(32'h800, data, resp, ok);
    checks++;
    if (!ok || data !== 32'h0 || resp !== 2'b10) begin
      errors++;
      $display("FAIL oor_read: ok=%0b rdata=%h rresp=%b expected 00000000/10", ok, data, resp);
    end
    do_read(32'h7FC, data, resp, ok);
    checks++;
    if (!ok || data !== 32'h5A5A0FF0 || resp !== 2'b00) begin
      errors++;
      $display("FAIL oor_last_word_kept: rdata=%h rresp=%b expected 5A5A0FF0/00", data, resp);
    end
    do_read(32'h000, data, resp, ok);
    checks++;
    if (!ok || data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL oor_word0_kept: rdata=%h expected 0BADF00D", data);
    end
  endtask

  task automatic test_b_backpressure();
    logic [1:0] resp;
    logic [31:0] data;
    logic ok;
    bus.axi_bready = 1'b0;
    bus.axi_awaddr = 32'h200;
    bus.axi_wdata = 32'h00000001;
    bus.axi_wstrb = 4'hF;
    checks++;
    if ({bus.axi_awready, bus.axi_wready} !== 2'b11) begin
      errors++;
      $display("FAIL bp_idle_ready: got %b expected 11", {bus.axi_awready, bus.axi_wready});
    end
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid = 1'b0;
    tick();
    checks++;
    if (bus.axi_bvalid !== 1'b1 || bus.axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_b: bvalid=%b awready=%b expected 1/1", bus.axi_bvalid, bus.axi_awready);
    end
    bus.axi_awaddr = 32'h204;
    bus.axi_wdata = 32'h00000002;
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.axi_bvalid, bus.axi_awready, bus.axi_wready} !== 3'b100) begin
        errors++;
        $display("FAIL bp_hold_%0d: bvalid/awready/wready=%b expected 100", i, {bus.axi_bvalid, bus.axi_awready, bus.axi_wready});
      end
      tick();
    end
    bus.axi_bready = 1'b1;
    tick();
    checks++;
    if (bus.axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_gap: bvalid=%b expected 0", bus.axi_bvalid);
    end
    tick();
    checks++;
    if (bus.axi_bvalid !== 1'b1 || bus.axi_bresp !== 2'b00) begin
      errors++;
      $display("FAIL bp_second_b: bvalid=%b bresp=%b expected 1/00", bus.axi_bvalid, bus.axi_bresp);
    end
    tick();
    bus.axi_bready = 1'b0;
    do_read(32'h200, data, resp, ok);
    checks++;
    if (!ok || data !== 32'h00000001) begin
      errors++;
      $display("FAIL bp_read_first: rdata=%h expected 00000001", data);
    end
    do_read(32'h204, data, resp, ok);
    checks++;
    if (!ok || data !== 32'h00000002) begin
      errors++;
      $display("FAIL bp_read_second: rdata=%h expected 00000002", data);
    end
  endtask

  task automatic test_contention_and_reset();
    logic [1:0] resp;
    logic [31:0] data;
    logic ok;
    int bcyc, rcyc;
    do_write(32'h100, 32'h11111111, 4'hF, resp, ok);
    areset = 1'b1;
    tick(); tick();
    areset = 1'b0;
    tick();
    checks++;
    if ({bus.axi_awready, bus.axi_wready, bus.axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL cont_ready: got %b expected 111", {bus.axi_awready, bus.axi_wready, bus.axi_arready});
    end
    bus.axi_awaddr = 32'h100;
    bus.axi_wdata = 32'h22222222;
    bus.axi_wstrb = 4'hF;
    bus.axi_araddr = 32'h100;
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid = 1'b1;
    bus.axi_arvalid = 1'b1;
    bus.axi_bready = 1'b1;
    bus.axi_rready = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid = 1'b0;
    bus.axi_arvalid = 1'b0;
    bcyc = -1;
    rcyc = -1;
    data = 'x;
    for (int c = 1; c <= 20 && rcyc < 0; c++) begin
      if (bus.axi_bvalid && bcyc < 0) bcyc = c;
      if (bus.axi_rvalid) begin
        rcyc = c;
        data = bus.axi_rdata;
      end
      tick();
    end
    bus.axi_bready = 1'b0;
    bus.axi_rready = 1'b0;
    checks++;
    if (bcyc != 2) begin
      errors++;
      $display("FAIL cont_b_cycle: bvalid at cycle %0d expected 2", bcyc);
    end
    checks++;
    if (rcyc <= bcyc) begin
      errors++;
      $display("FAIL cont_order: rvalid cycle %0d bvalid cycle %0d expected write first", rcyc, bcyc);
    end
    checks++;
    if (data !== 32'h22222222) begin
      errors++;
      $display("FAIL cont_rdata: rdata=%h expected 22222222", data);
    end
    bus.axi_araddr = 32'h100;
    bus.axi_arvalid = 1'b1;
    tick();
    bus.axi_arvalid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.axi_rvalid !== 1'b1 || bus.axi_arready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pending: rvalid=%b arready=%b expected 1/0", bus.axi_rvalid, bus.axi_arready);
    end
    areset = 1'b1;
    tick();
    checks++;
    if (bus.axi_rvalid !== 1'b0 || bus.axi_arready !== 1'b0) begin
      errors++;
      $display("FAIL rst_during: rvalid=%b arready=%b expected 0/0", bus.axi_rvalid, bus.axi_arready);
    end
    areset = 1'b0;
    tick();
    checks++;
    if (bus.axi_rvalid !== 1'b0 || bus.axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: rvalid=%b arready=%b expected 0/1", bus.axi_rvalid, bus.axi_arready);
    end
    do_read(32'h100, data, resp, ok);
    checks++;
    if (!ok || data !== 32'h22222222 || resp !== 2'b00) begin
      errors++;
      $display("FAIL rst_reread: ok=%0b rdata=%h rresp=%b expected 22222222/00", ok, data, resp);
    end
  endtask

  initial begin
    areset = 1'b1;
    bus.axi_awaddr = '0;
    bus.axi_awvalid = 1'b0;
    bus.axi_wdata = '0;
    bus.axi_wstrb = '0;
    bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_araddr = '0;
    bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b0;
    test_reset();
    test_basic();
    test_w_before_aw();
    test_out_of_range();
    test_b_backpressure();
    test_contention_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- Parametrised AXI4-Lite slave fronting a single-port, byte-enabled on-chip SRAM.
- Generalised successor of the fixed 512-entry SRAM wrapper, with configurable data width, depth and base address.
- Adds independent AW/W acceptance, out-of-range SLVERR responses and round-robin read/write arbitration.
- Sits on the accelerator's control/data AXI-Lite interconnect as a key/state scratch memory.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, data width; one of 32, 64, 128
DEPTH, 512, number of DATA_W words; need not be a power of two
BASE_ADDR, 0, byte address mapped to word 0; must be aligned to DATA_W/8

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
axi_awaddr  in  ADDR_W  write address
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_wdata  in  DATA_W  write data
axi_wstrb  in  DATA_W/8  byte strobes
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_bresp  out  2  write response
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready
axi_araddr  in  ADDR_W  read address
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_rdata  out  DATA_W  read data
axi_rresp  out  2  read response
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready

Behaviour:
- Interface decision: one clock, aclk; reset areset is synchronous and active-high.
- Reset values:
  - All readys, bvalid and rvalid are 0.
  - bresp, rresp and rdata are 0.
  - aw_full, w_full, rd_busy and the arbiter pointer are cleared; the arbiter favours write.
  - SRAM contents are not reset.
- Readys are registered. They read 1 from the first edge after areset falls: awready = !aw_full, wready = !w_full, arready = !rd_busy.
- AW and W are captured independently into one-entry holding registers, in either order, same cycle or any cycle apart.
- Write fire: requires aw_full && w_full && !bvalid && write granted.
  - SRAM write uses wstrb as byte enables, suppressed if the address is out of range.
  - Next cycle: bvalid=1, bresp=OKAY(00) or SLVERR(10); aw_full and w_full clear.
  - awready/wready return the cycle after the fire.
- bvalid and bresp are held until bready; the next write cannot fire while bvalid=1.
- Read path:
  - AR handshake sets rd_busy and captures the address.
  - SRAM read issues when granted; rvalid=1 the cycle after issue, latency 1.
  - rdata/rresp are held stable until rready.
  - R handshake clears rd_busy; arready returns the next cycle.
  - Out-of-range read returns rdata=0, rresp=SLVERR, with no SRAM access.
- Address decode:
  - index = (addr − BASE_ADDR) >> log2(DATA_W/8); in range iff addr ≥ BASE_ADDR and index < DEPTH.
  - Low byte-offset bits are ignored, so unaligned addresses are treated as aligned.
- Arbitration for the single SRAM port:
  - If a write fire and a read issue are both eligible, the pointer picks one; the pointer toggles after each contested grant.
  - An uncontested request is granted immediately.
- Ordering: a read issued in a cycle after a write fire observes the new data. There is no ordering between simultaneously pending read and write beyond arbitration.
- areset mid-transaction: pending AW/W/AR and pending B/R are dropped with no response; an in-flight SRAM write completes or not, content is undefined only for that word.
- Maximum one outstanding write and one outstanding read.

Optional Feature:
- Macro AXI_SRAM_RD_PIPE_EN.
- Defined: adds an output register after the SRAM, giving read latency 2 (rvalid two cycles after issue). The write path is unchanged.
- Undefined: read latency 1 as above.

Decomposition:
- Package axi_sram_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - A function clog2.
  - An enum for arbiter grant {GNT_WR, GNT_RD}.
- Sub-module sram_sp_be: single-port, byte-enabled synchronous RAM parametrised on DATA_W and DEPTH, with 1-cycle read.

Test Plan:
1. Write 0xDEADBEEF to 0x100, wstrb=4'hF, then read 0x100 -> bresp=00; rvalid with rdata=0xDEADBEEF, rresp=00.
2. Then write 0x00001234 to 0x100 with wstrb=4'b0011 and read -> rdata=0xDEAD1234.
3. W presented 3 cycles before AW (addr 0x104, data 0xA5A5A5A5) -> exactly one bvalid, asserted 2 cycles after the AW handshake; readback 0xA5A5A5A5.
4. Write and read at BASE_ADDR+DEPTH*4 (0x800) -> bresp=10, rresp=10, rdata=0; word 0x7FC remains unchanged.
5. Hold bready=0 for 5 cycles with a second AW/W offered -> bvalid stays 1 and the second pair is captured but does not fire; its B arrives after the first B handshake.
6. After reset, AW/W and AR to 0x100 in the same cycle, prior content 0x11111111, new data 0x22222222 -> write wins the first contest, read returns 0x22222222. Assert areset during the next pending read -> rvalid=0 and arready=1 one cycle after release.
